// File: rtl/adder_4.sv
// 4-bit carry-lookahead adder with registered sum, carry-out and group generate/propagate.
// Latency 1 cycle, one result per cycle; no handshake, so there is no backpressure.
module adder_4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Ci,
    output logic [3:0] S,
    output logic       Co,
    output logic       Go,
    output logic       Po
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;
    logic [3:0] w_sum;
    logic       w_gn;
    logic       w_pn;
    logic       w_con;

    logic [3:0] r_s;
    logic       r_co;
    logic       r_go;
    logic       r_po;

    assign w_g = A & B;
    assign w_p = A ^ B;

    // Every carry is a flat sum-of-products so no carry waits on another.
    assign w_c[0] = Ci;
    assign w_c[1] = w_g[0]
                  | (w_p[0] & Ci);
    assign w_c[2] = w_g[1]
                  | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & Ci);
    assign w_c[3] = w_g[2]
                  | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & Ci);

    assign w_gn = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign w_pn  = &w_p;
    assign w_con = w_gn | (w_pn & Ci);
    assign w_sum = w_p ^ w_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s  <= 4'h0;
            r_co <= 1'b0;
            r_go <= 1'b0;
            r_po <= 1'b0;
        end else begin
            r_s  <= w_sum;
            r_co <= w_con;
            r_go <= w_gn;
            r_po <= w_pn;
        end
    end

    assign S  = r_s;
    assign Co = r_co;
    assign Go = r_go;
    assign Po = r_po;

endmodule

// File: tb/tb_adder_4.sv
// Self-checking bench for adder_4: directed vectors, exhaustive sweep, random vectors, reset behaviour.
module tb_adder_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic       Ci;
    logic [3:0] S;
    logic       Co;
    logic       Go;
    logic       Po;

    int         n_cmp;
    int         n_bad;
    logic [6:0] prev_exp;

    adder_4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .Ci    (Ci),
        .S     (S),
        .Co    (Co),
        .Go    (Go),
        .Po    (Po)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {Co,S,Go,Po} from plain arithmetic.
    // Group generate means A+B alone overflows; group propagate means A+B is exactly 15.
    function automatic logic [6:0] model(input int a, input int b, input int ci);
        int total;
        logic [4:0] t5;
        logic go;
        logic po;
        total = a + b + ci;
        t5 = total[4:0];
        go = (a + b) > 15;
        po = (a + b) == 15;
        return {t5, go, po};
    endfunction

    function automatic logic [6:0] observed();
        return {Co, S, Go, Po};
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got {Co,S,Go,Po}=%b, required %b", tag, obs, exp_v);
        end
    endtask

    // Called just after a rising edge: applies inputs, confirms outputs do not
    // move combinationally, then checks the result one edge later.
    task automatic drive(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic ci, input logic [6:0] exp_v);
        A  = a;
        B  = b;
        Ci = ci;
        #1;
        chk({tag, "_hold"}, observed(), prev_exp);
        @(posedge clk);
        #1;
        chk(tag, observed(), exp_v);
        chk({tag, "_go_po_excl"}, {6'd0, Go & Po}, 7'd0);
        prev_exp = exp_v;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        prev_exp = 7'd0;
        rst_n    = 1'b1;
        A        = 4'd3;
        B        = 4'd4;
        Ci       = 1'b0;

        // Reset asserted before any clock edge must clear outputs at once.
        #1 rst_n = 1'b0;
        #1;
        chk("reset_async", observed(), 7'd0);
        @(posedge clk);
        #1;
        chk("reset_held_edge", observed(), 7'd0);

        // Release between edges: outputs stay at reset until the next edge.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_release_hold", observed(), 7'd0);
        @(posedge clk);
        #1;
        chk("first_edge_load", observed(), model(3, 4, 0));
        prev_exp = model(3, 4, 0);

        drive("dir_5_7_0",   4'd5,  4'd7, 1'b0, 7'b0110000);
        drive("dir_15_1_0",  4'd15, 4'd1, 1'b0, 7'b1000010);
        drive("dir_10_5_1",  4'd10, 4'd5, 1'b1, 7'b1000001);
        drive("dir_7_8_0",   4'd7,  4'd8, 1'b0, 7'b0111101);

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = i[8:0];
            drive("sweep", v[8:5], v[4:1], v[0], model(int'(v[8:5]), int'(v[4:1]), int'(v[0])));
        end

        for (int i = 0; i < 200; i++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            logic       rc;
            ra = 4'($urandom_range(15, 0));
            rb = 4'($urandom_range(15, 0));
            rc = 1'($urandom_range(1, 0));
            drive("random", ra, rb, rc, model(int'(ra), int'(rb), int'(rc)));
        end

        // Mid-stream reset: maximum result, then reset between edges.
        drive("max_before_reset", 4'd15, 4'd15, 1'b1, 7'b1111110);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midstream_reset_async", observed(), 7'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("midstream_release_hold", observed(), 7'd0);
        @(posedge clk);
        #1;
        chk("midstream_first_edge", observed(), 7'b1111110);
        prev_exp = 7'b1111110;

        drive("after_reset", 4'd9, 4'd6, 1'b0, model(9, 6, 0));
        drive("after_reset_ci", 4'd0, 4'd0, 1'b1, model(0, 0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adder_4.md
ADDER_4 -- requirements
Module: adder_4

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 4 bits.
REQ-002 The block SHALL use one clock and one reset; the reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all registers.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 A  input  4  addend A, unsigned.
REQ-006 B  input  4  addend B, unsigned.
REQ-007 Ci  input  1  carry-in.
REQ-008 S  output  4  registered sum bits.
REQ-009 Co  output  1  registered carry-out.
REQ-010 Go  output  1  registered group generate.
REQ-011 Po  output  1  registered group propagate.

Function
REQ-012 Bit i SHALL have generate g[i] = A[i] & B[i], for i = 0..3.
REQ-013 Bit i SHALL have propagate p[i] = A[i] ^ B[i], for i = 0..3.
REQ-014 Carries SHALL be computed by lookahead, not ripple; each c[i+1] SHALL be a flat sum-of-products of g, p and Ci:
- c0 = Ci
- c1 = g0 | p0&Ci
- c2 = g1 | p1g0 | p1p0Ci
- c3 = g2 | p2g1 | p2p1g0 | p2p1p0Ci
REQ-015 Group generate SHALL be Gn = g3 | p3g2 | p3p2g1 | p3p2p1g0; it SHALL be independent of Ci.
REQ-016 Group propagate SHALL be Pn = p3&p2&p1&p0.
REQ-017 Carry-out SHALL be Con = Gn | (Pn & Ci).
REQ-018 Sum SHALL be Sn[i] = p[i] ^ c[i].
REQ-019 The result {Con,Sn} SHALL equal A + B + Ci, in the range 0..31.
REQ-020 Timing: on every rising clk edge with rst_n high, S, Co, Go and Po SHALL load Sn, Con, Gn and Pn computed from the A, B and Ci present at that edge.
REQ-021 Latency SHALL be exactly 1 cycle; throughput SHALL be one result per cycle.
REQ-022 There SHALL be no handshake and no enable; all registers update every cycle.
REQ-023 Overflow wrap: when A + B + Ci ≥ 16, S SHALL hold the low 4 bits and Co SHALL be 1; no other overflow indication exists.
REQ-024 Go and Po SHALL never both be 1.
REQ-025 Go and Po SHALL be registered with the same edge as S and Co, so all four outputs are always mutually consistent.
REQ-026 No output SHALL depend combinationally on A, B or Ci.

Reset
REQ-027 While rst_n is 0, S SHALL be 4'h0 and Co, Go, Po SHALL be 0.
REQ-028 These reset values SHALL take effect immediately, independent of clk.
REQ-029 On rst_n deassertion, outputs SHALL hold the reset values until the first rising clk edge with rst_n high.
REQ-030 At that first edge, outputs SHALL load the result of the inputs then present.
REQ-031 If rst_n is asserted mid-stream, any in-flight result SHALL be discarded and outputs SHALL go to the reset values.

Verification
REQ-032 A=5, B=7, Ci=0, one clock -> S=12, Co=0, Go=0, Po=0.
REQ-033 A=15, B=1, Ci=0 -> S=0, Co=1, Go=1, Po=0.
REQ-034 A=10, B=5, Ci=1 -> S=0, Co=1, Go=0, Po=1.
REQ-035 A=7, B=8, Ci=0 -> S=15, Co=0, Go=0, Po=1.
REQ-036 Exhaustive sweep of all 512 (A,B,Ci) combinations, one per cycle:
- each result SHALL appear exactly one cycle after its inputs;
- {Co,S} SHALL equal A+B+Ci for every combination;
- Go and Po SHALL match the REQ-015/016 equations for every combination.
REQ-037 Reset case: drive A=15, B=15, Ci=1 and clock once -> S=15, Co=1.
- Then pull rst_n low between clock edges -> all outputs 0 immediately.
- Release rst_n -> outputs stay 0 until the next rising edge.
